// File: rtl/book_snapshot_dumper.sv
// Snapshot engine: once the matching engine is idle it takes over the heap
// BRAM read port and streams every selected side as a framed beat sequence
// (header, live entries, one trailer) through a 2-entry valid/ready FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_dump; side_mask latched on the request
// WAIT_BUSY | waiting for engine_busy_in=0; counts latched on exit
// ARM       | BRAM port taken over; selects the lowest masked side
// HEADER    | pushes the side header; empty side skips straight on
// READ      | issues reads at addresses 1..count under FIFO credit
// DRAIN     | final read lands this cycle; selects the next side
// TRAILER   | pushes the trailer beat
// FLUSH     | waits until the last beat has been accepted
// RELEASE   | dump_done pulse, BRAM port handed back
module book_snapshot_dumper #(
  parameter int NUM_SIDES   = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int MAX_ENTRIES = 1023,
  parameter bit SKIP_ZERO   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start_dump,
  input  logic [NUM_SIDES-1:0]          i_side_mask,
  input  logic                          i_engine_busy_in,
  input  logic [NUM_SIDES*ADDR_W-1:0]   i_side_count,
  input  logic [NUM_SIDES*DATA_W-1:0]   i_bram_rdata,
  output logic                          o_dump_active,
  output logic [ADDR_W-1:0]             o_dump_addr,
  output logic                          o_out_valid,
  output logic [DATA_W-1:0]             o_out_data,
  input  logic                          i_out_ready,
  output logic                          o_dump_busy,
  output logic                          o_dump_done
);

  localparam int SIDE_W = (NUM_SIDES > 1) ? $clog2(NUM_SIDES) : 1;
  localparam int EMIT_W = ADDR_W + 4;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BUSY, S_ARM, S_HEADER, S_READ,
    S_DRAIN, S_TRAILER, S_FLUSH, S_RELEASE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_SIDES-1:0] r_mask;
  logic [ADDR_W-1:0]   r_cnt [NUM_SIDES];
  logic [ADDR_W-1:0]   w_cnt_clamp [NUM_SIDES];
  logic [SIDE_W-1:0]   r_side;
  logic [ADDR_W-1:0]   r_dump_addr, w_addr_nxt;
  logic                r_pending;
  logic [EMIT_W-1:0]   r_emitted;

  logic [DATA_W-1:0]   r_mem [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_fifo_cnt;

  logic                w_sel_found;
  logic [SIDE_W-1:0]   w_sel_side;
  logic [ADDR_W-1:0]   w_cur_cnt;
  logic [DATA_W-1:0]   w_rdata, w_header, w_trailer, w_push_data;
  logic                w_pop, w_room, w_credit, w_push;
  logic                w_hdr_push, w_trl_push, w_cap_push, w_issue, w_side_load;
  logic [2:0]          w_occ;

  // Lowest masked side: from side 0 in ARM, otherwise above the current side.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_side  = '0;
    for (int i = NUM_SIDES - 1; i >= 0; i--) begin
      if (r_mask[i] && (r_state == S_ARM || i > int'(r_side))) begin
        w_sel_found = 1'b1;
        w_sel_side  = SIDE_W'(i);
      end
    end
  end

  // Per-side views: clamped live counts and the current side's count/data.
  always_comb begin
    w_cur_cnt = '0;
    w_rdata   = '0;
    for (int i = 0; i < NUM_SIDES; i++) begin
      w_cnt_clamp[i] = (i_side_count[i*ADDR_W +: ADDR_W] > ADDR_W'(MAX_ENTRIES)) ?
                       ADDR_W'(MAX_ENTRIES) : i_side_count[i*ADDR_W +: ADDR_W];
      if (r_side == SIDE_W'(i)) begin
        w_cur_cnt = r_cnt[i];
        w_rdata   = i_bram_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Frame words and FIFO flow control; credit counts the read still in flight.
  always_comb begin
    w_header = '0;
    w_header[DATA_W-1 -: 8] = 8'hA5;
    w_header[DATA_W-9 -: 8] = 8'(r_side);
    w_header[ADDR_W-1:0]    = w_cur_cnt;
    w_trailer = '0;
    w_trailer[DATA_W-1 -: 8] = 8'h5A;
    w_trailer[EMIT_W-1:0]    = r_emitted;
    w_pop      = o_out_valid & i_out_ready;
    w_room     = (r_fifo_cnt != 2'd2) || w_pop;
    w_occ      = {1'b0, r_fifo_cnt} - {2'b0, w_pop} + {2'b0, r_pending};
    w_credit   = (w_occ < 3'd2);
    w_cap_push = r_pending && !(SKIP_ZERO && (w_rdata == '0));
    w_push     = w_hdr_push | w_trl_push | w_cap_push;
    w_push_data = w_hdr_push ? w_header : (w_trl_push ? w_trailer : w_rdata);
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_dump_addr;
    w_hdr_push  = 1'b0;
    w_trl_push  = 1'b0;
    w_issue     = 1'b0;
    w_side_load = 1'b0;
    case (r_state)
      S_IDLE:      if (i_start_dump) w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!i_engine_busy_in) w_state_nxt = S_ARM;
      S_ARM: begin
        w_side_load = w_sel_found;
        w_state_nxt = w_sel_found ? S_HEADER : S_TRAILER;
      end
      S_HEADER: begin
        if (w_room) begin
          w_hdr_push = 1'b1;
          if (w_cur_cnt == '0) begin
            w_side_load = w_sel_found;
            w_state_nxt = w_sel_found ? S_HEADER : S_TRAILER;
          end else begin
            w_addr_nxt  = ADDR_W'(1);
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_dump_addr == w_cur_cnt) w_state_nxt = S_DRAIN;
          else                          w_addr_nxt  = r_dump_addr + ADDR_W'(1);
        end
      end
      // The last read was issued on the previous edge, so it lands on this one.
      S_DRAIN: begin
        w_side_load = w_sel_found;
        w_state_nxt = w_sel_found ? S_HEADER : S_TRAILER;
      end
      S_TRAILER: begin
        if (w_room) begin
          w_trl_push  = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH:   if (r_fifo_cnt == 2'd0) w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        w_addr_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, latched request, side, address, read tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_side      <= '0;
      r_dump_addr <= '0;
      r_pending   <= 1'b0;
      r_emitted   <= '0;
      for (int i = 0; i < NUM_SIDES; i++) r_cnt[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dump_addr <= w_addr_nxt;
      r_pending   <= w_issue;
      if (r_state == S_IDLE && i_start_dump) r_mask <= i_side_mask;
      if (r_state == S_WAIT_BUSY && !i_engine_busy_in) begin
        for (int i = 0; i < NUM_SIDES; i++) r_cnt[i] <= w_cnt_clamp[i];
      end
      if (w_side_load) r_side <= w_sel_side;
      if (r_state == S_ARM)                       r_emitted <= '0;
      else if (w_cap_push && (r_emitted != '1))   r_emitted <= r_emitted + EMIT_W'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage; contents are only visible while occupancy is nonzero.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign o_dump_active = (r_state != S_IDLE) && (r_state != S_WAIT_BUSY) &&
                         (r_state != S_RELEASE);
  assign o_dump_busy   = (r_state != S_IDLE);
  assign o_dump_done   = (r_state == S_RELEASE);
  assign o_dump_addr   = r_dump_addr;
  assign o_out_valid   = (r_fifo_cnt != 2'd0);
  assign o_out_data    = o_out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_book_snapshot_dumper.sv
// Bench for book_snapshot_dumper: BRAM model, expected-beat queue filled
// when each dump is requested, and a monitor popping on every accepted beat.
module tb_book_snapshot_dumper;
  localparam int NS = 2;
  localparam int DW = 32;
  localparam int AW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [NS-1:0]  side_mask = '0;
  logic           busy = 1'b0;
  logic [NS*AW-1:0] side_count = '0;
  logic [NS*DW-1:0] bram_rdata;
  logic           dump_active, out_valid, dump_busy, dump_done;
  logic [AW-1:0]  dump_addr;
  logic [DW-1:0]  out_data;
  logic           out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  bit addr_seen = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  logic [DW-1:0] prev_data;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] mem [0:1][0:1023];

  always #5 clk = ~clk;

  book_snapshot_dumper #(.NUM_SIDES(NS), .DATA_W(DW), .ADDR_W(AW),
                         .MAX_ENTRIES(1023), .SKIP_ZERO(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start_dump(start), .i_side_mask(side_mask),
    .i_engine_busy_in(busy), .i_side_count(side_count), .i_bram_rdata(bram_rdata),
    .o_dump_active(dump_active), .o_dump_addr(dump_addr), .o_out_valid(out_valid),
    .o_out_data(out_data), .i_out_ready(out_ready), .o_dump_busy(dump_busy),
    .o_dump_done(dump_done));

  // synchronous-read BRAMs, one cycle latency
  always @(posedge clk) begin
    bram_rdata[DW-1:0]    <= mem[0][dump_addr];
    bram_rdata[2*DW-1:DW] <= mem[1][dump_addr];
  end

  // sink ready pattern, changed just after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 1) ? ~out_ready : 1'b1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (dump_done === 1'b1) done_cnt++;
    if (dump_addr !== '0) addr_seen = 1'b1;
    if (prev_stall === 1'b1) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                 out_valid, out_data, prev_data);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got %h required no beat", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (out_data !== exp_w) begin
          n_err++;
          $display("FAIL beat: got %h required %h", out_data, exp_w);
        end
      end
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_frame(input logic [1:0] m, input int c0, input int c1);
    int emitted;
    int cnt;
    emitted = 0;
    for (int s = 0; s < NS; s++) begin
      if (m[s]) begin
        cnt = (s == 0) ? c0 : c1;
        exp_q.push_back({8'hA5, 8'(s), 16'(cnt)});
        for (int a = 1; a <= cnt; a++) begin
          if (mem[s][a] != '0) begin
            exp_q.push_back(mem[s][a]);
            emitted++;
          end
        end
      end
    end
    exp_q.push_back({8'h5A, 24'(emitted)});
  endtask

  task automatic kick(input logic [1:0] m, input int c0, input int c1);
    side_mask  = m;
    side_count = {AW'(c1), AW'(c0)};
    done_cnt   = 0;
    addr_seen  = 1'b0;
    add_frame(m, c0, c1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: dump_done not seen in %0d cycles", t);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic set_basic_mem();
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 1024; a++) mem[s][a] = '0;
    mem[0][1] = 32'h1111_000A; mem[0][2] = 32'h2222_000B; mem[0][3] = 32'h3333_000C;
    mem[1][1] = 32'h4444_000D; mem[1][2] = 32'h5555_000E;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 6;
    if (dump_active !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b required 0", dump_active); end
    if (dump_addr !== '0)     begin n_err++; $display("FAIL rst_addr: got %h required 0", dump_addr); end
    if (out_valid !== 1'b0)   begin n_err++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if (out_data !== '0)      begin n_err++; $display("FAIL rst_data: got %h required 0", out_data); end
    if (dump_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b required 0", dump_busy); end
    if (dump_done !== 1'b0)   begin n_err++; $display("FAIL rst_done: got %b required 0", dump_done); end
  endtask

  task automatic test_basic();
    int lat;
    set_basic_mem();
    kick(2'b11, 3, 2);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin n_err++; $display("FAIL latency: got %0d required 3", lat); end
    // a second request mid-dump must be ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    n_cmp += 4;
    if (done_cnt != 1)       begin n_err++; $display("FAIL basic_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0)   begin n_err++; $display("FAIL basic_left: got %0d required 0", exp_q.size()); end
    if (dump_busy !== 1'b0)  begin n_err++; $display("FAIL basic_busy: got %b required 0", dump_busy); end
    if (dump_active !== 1'b0) begin n_err++; $display("FAIL basic_active: got %b required 0", dump_active); end
  endtask

  task automatic test_backpressure();
    set_basic_mem();
    rdy_mode = 1;
    kick(2'b11, 3, 2);
    wait_done();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    n_cmp += 2;
    if (done_cnt != 1)     begin n_err++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_skip_zero();
    set_basic_mem();
    mem[0][1] = 32'hDEAD_0001; mem[0][2] = 32'h0; mem[0][3] = 32'hBEEF_0003;
    kick(2'b01, 3, 2);
    wait_done();
    n_cmp += 2;
    if (done_cnt != 1)     begin n_err++; $display("FAIL skip_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL skip_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_busy_hold();
    bit early;
    set_basic_mem();
    busy = 1'b1;
    kick(2'b11, 3, 2);
    early = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dump_active !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early) begin n_err++; $display("FAIL busy_hold: dump_active rose while busy, required 0"); end
    busy = 1'b0;
    n_cmp++;
    if (dump_active !== 1'b0) begin n_err++; $display("FAIL busy_drop: got %b required 0", dump_active); end
    @(negedge clk);
    n_cmp++;
    if (dump_active !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %b required 1", dump_active); end
    wait_done();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL busy_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_empty_side();
    set_basic_mem();
    kick(2'b10, 3, 0);
    wait_done();
    n_cmp += 2;
    if (addr_seen)         begin n_err++; $display("FAIL empty_reads: got reads required none"); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL empty_left: got %0d required 0", exp_q.size()); end
    kick(2'b00, 3, 2);
    wait_done();
    n_cmp += 3;
    if (addr_seen)         begin n_err++; $display("FAIL nomask_reads: got reads required none"); end
    if (done_cnt != 1)     begin n_err++; $display("FAIL nomask_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL nomask_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int t;
    set_basic_mem();
    for (int a = 1; a <= 8; a++) mem[0][a] = 32'h0100_0000 + a;
    kick(2'b01, 8, 0);
    t = 0;
    while (dump_addr !== AW'(3) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 200) begin n_err++; $display("FAIL mid_reach: dump_addr=%0d required 3", dump_addr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 3;
    if (dump_active !== 1'b0) begin n_err++; $display("FAIL mid_active: got %b required 0", dump_active); end
    if (out_valid !== 1'b0)   begin n_err++; $display("FAIL mid_valid: got %b required 0", out_valid); end
    if (dump_busy !== 1'b0)   begin n_err++; $display("FAIL mid_busy: got %b required 0", dump_busy); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    set_basic_mem();
    kick(2'b11, 3, 2);
    wait_done();
    n_cmp += 2;
    if (done_cnt != 1)     begin n_err++; $display("FAIL mid_done: got %0d required 1", done_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    set_basic_mem();
    test_reset();
    test_basic();
    test_backpressure();
    test_skip_zero();
    test_busy_hold();
    test_empty_side();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
